// File: rtl/wb_sram16_slave_if.sv
// rtl/wb_sram16_slave_if.sv - Wishbone classic bus bundle for the 16-bit SRAM slave
// Signal names follow the slave's view of the bus.
interface wb_sram16_slave_if;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        ack_o;

  modport slave (
    input  adr_i, dat_i, cyc_i, stb_i, we_i, sel_i,
    output dat_o, ack_o
  );

  modport master (
    output adr_i, dat_i, cyc_i, stb_i, we_i, sel_i,
    input  dat_o, ack_o
  );
endinterface

// File: rtl/wb_sram16_slave.sv
// rtl/wb_sram16_slave.sv - Wishbone slave serving 32-bit words from async 16-bit SRAM
// Optional next-word read prefetch is built when SRAM_PREFETCH_EN is defined.
module wb_sram16_slave #(
  parameter int SRAM_AW     = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_sram16_slave_if.slave   bus,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_dq_i,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);
  localparam int         WW       = SRAM_AW - 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI, WR_LO, WR_GAP, WR_HI, ACK
`ifdef SRAM_PREFETCH_EN
    , PF_LO, PF_HI
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic [WW-1:0] word_q;
  logic [31:0]   wdat_q;
  logic [31:0]   rdat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          abort_q;
  logic          req, last, ack;
  logic [WW-1:0] req_word;
  logic [WW-1:0] sram_word;
  logic          sram_half;
  logic          unused_adr;

  assign req        = bus.cyc_i & bus.stb_i;
  assign req_word   = bus.adr_i[SRAM_AW:2];
  assign last       = (cnt == 4'd0);
  assign ack        = (state == ACK) & req & ~abort_q;
  assign bus.ack_o  = ack;
  assign bus.dat_o  = rdat_q;
  assign unused_adr = &{1'b0, bus.adr_i};

`ifdef SRAM_PREFETCH_EN
  logic [WW-1:0] pf_adr;
  logic [31:0]   pf_data;
  logic          pf_valid;
  logic          pf_hit;

  assign pf_hit = pf_valid & ~bus.we_i & (req_word == pf_adr);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (!bus.we_i) begin
`ifdef SRAM_PREFETCH_EN
            state_nxt = pf_hit ? ACK : RD_LO;
`else
            state_nxt = RD_LO;
`endif
          end
          else if (bus.sel_i[3:2] != 2'b00) state_nxt = WR_LO;
          else if (bus.sel_i[1:0] != 2'b00) state_nxt = WR_HI;
          else                              state_nxt = ACK;
        end
      end
      RD_LO:  if (last) state_nxt = RD_HI;
      RD_HI:  if (last) state_nxt = ACK;
      WR_LO:  if (last) state_nxt = (sel_q[1:0] != 2'b00) ? WR_GAP : ACK;
      WR_GAP: state_nxt = WR_HI;
      WR_HI:  if (last) state_nxt = ACK;
`ifdef SRAM_PREFETCH_EN
      ACK:    state_nxt = (ack && !we_q) ? PF_LO : IDLE;
      PF_LO:  if (last) state_nxt = PF_HI;
      PF_HI:  if (last) state_nxt = IDLE;
`else
      ACK:    state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from the state register so reset releases them at once.
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_dq_oe = 1'b0;
    sram_dq_o  = wdat_q[31:16];
    sram_half  = 1'b0;
    sram_word  = word_q;
    case (state)
      RD_LO, RD_HI: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        sram_half = (state == RD_HI);
      end
      WR_LO, WR_GAP: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = (state == WR_GAP);
        sram_dq_oe = 1'b1;
        sram_ub_n  = ~sel_q[3];
        sram_lb_n  = ~sel_q[2];
      end
      WR_HI: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
        sram_ub_n  = ~sel_q[1];
        sram_lb_n  = ~sel_q[0];
        sram_dq_o  = wdat_q[15:0];
        sram_half  = 1'b1;
      end
`ifdef SRAM_PREFETCH_EN
      PF_LO, PF_HI: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        sram_half = (state == PF_HI);
        sram_word = pf_adr;
      end
`endif
      default: ;
    endcase
    sram_addr = {sram_word, sram_half};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt     <= '0;
      word_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
`ifdef SRAM_PREFETCH_EN
      pf_adr   <= '0;
      pf_data  <= '0;
      pf_valid <= 1'b0;
`endif
    end else begin
      if (state_nxt != state) cnt <= CNT_INIT;
      else if (!last)         cnt <= cnt - 4'd1;

      // An abandoned cycle still runs its SRAM sequence but must not be acked.
      if (state == IDLE && req) begin
        word_q  <= req_word;
        wdat_q  <= bus.dat_i;
        sel_q   <= bus.sel_i;
        we_q    <= bus.we_i;
        abort_q <= 1'b0;
      end else if (state != IDLE && !bus.cyc_i) begin
        abort_q <= 1'b1;
      end

      if (state == RD_LO && last) rdat_q[31:16] <= sram_dq_i;
      if (state == RD_HI && last) rdat_q[15:0]  <= sram_dq_i;

`ifdef SRAM_PREFETCH_EN
      if (state == IDLE && req && pf_hit)   rdat_q   <= pf_data;
      if (state == IDLE && req && bus.we_i) pf_valid <= 1'b0;
      if (state == ACK && state_nxt == PF_LO) begin
        pf_adr   <= word_q + 1'b1;
        pf_valid <= 1'b0;
      end
      if (state == PF_LO && last) pf_data[31:16] <= sram_dq_i;
      if (state == PF_HI && last) begin
        pf_data[15:0] <= sram_dq_i;
        pf_valid      <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: doc/wb_sram16_slave.md
Name: wb_sram16_slave

Overview:
- Wishbone classic slave that serves the video frame-buffer and CPU data region from external asynchronous 16-bit SRAM.
- It is the responder for the VGA scanline fetch master and the CPU bus. Each 32-bit Wishbone access is split into two sequential halfword SRAM cycles.
- SRAM strobe width is set by a wait-state parameter.

Parameters:
- SRAM_AW, 20, SRAM halfword address width; byte address bits [SRAM_AW:2] select the 32-bit word.
- WAIT_CYCLES, 2, cycles each halfword strobe is held active; legal range is 1..15.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- adr_i  in  32  byte address; bits [1:0] are ignored
- dat_i  in  32  write data
- dat_o  out  32  read data
- cyc_i  in  1  bus cycle
- stb_i  in  1  strobe
- we_i  in  1  write enable
- sel_i  in  4  byte selects; sel_i[3] maps to [31:24]
- ack_o  out  1  single-cycle acknowledge
- sram_addr  out  SRAM_AW  halfword address
- sram_dq_i  in  16  SRAM data in
- sram_dq_o  out  16  SRAM data out
- sram_dq_oe  out  1  data bus drive enable
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_ub_n  out  1  upper byte enable, active low
- sram_lb_n  out  1  lower byte enable, active low

Behaviour:
- Reset (asynchronous, rst_i; clock clk_i):
  - State goes to IDLE and dat_o=0, ack_o=0.
  - sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n and sram_lb_n all go to 1; sram_dq_oe=0, sram_addr=0.
  - Reset mid-transfer deasserts all strobes immediately. The transfer is dropped and no ack is issued.
- Word mapping:
  - Even halfword {adr_i[SRAM_AW:2],1'b0} holds [31:16]; ub_n=~sel[3], lb_n=~sel[2].
  - Odd halfword holds [15:0]; ub_n=~sel[1], lb_n=~sel[0].
  - Addresses wrap modulo SRAM size.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_GAP, WR_HI, ACK.
- IDLE:
  - On cyc_i&stb_i, latch adr, dat, sel and we, then go to RD_LO or WR_LO.
  - For a write whose even-half sel is 00, go directly to WR_HI.
- RD_LO and RD_HI:
  - ce_n=0, oe_n=0, both byte enables low, dq_oe=0.
  - Each lasts WAIT_CYCLES cycles; sram_dq_i is sampled on the last cycle into dat_o[31:16] or [15:0].
  - RD_LO goes to RD_HI; RD_HI goes to ACK.
- WR_LO and WR_HI:
  - ce_n=0, we_n=0, oe_n=1, dq_oe=1 with the proper data half; each lasts WAIT_CYCLES cycles.
  - WR_LO goes to WR_GAP for 1 cycle (we_n=1, address and data held), then to WR_HI.
  - If the odd-half sel is 00, WR_LO goes straight to ACK, skipping WR_GAP and WR_HI.
  - A write with sel=0000 goes IDLE to ACK with no SRAM activity.
- ACK:
  - ack_o=cyc_i&stb_i for exactly 1 cycle, then the state returns to IDLE.
  - Back-to-back requests therefore see at least one IDLE cycle.
- Latency from the IDLE sample edge to the ack cycle:
  - Read: 2*WAIT_CYCLES+1.
  - Full write: 2*WAIT_CYCLES+2.
  - Single-half write: WAIT_CYCLES+1.
- Abort handling:
  - If cyc_i drops mid-transfer, the SRAM sequence still completes so no partial strobe is left on the SRAM.
  - ack_o is suppressed in that case.
- dat_o holds the last read value; it does not change on writes.
- sram_addr is stable for the whole duration of each state.

Optional Feature:
- Macro: SRAM_PREFETCH_EN.
- With SRAM_PREFETCH_EN defined:
  - After each acked read, the block enters PF_LO/PF_HI while in IDLE to fetch word address+4 into pf_data, setting pf_valid and pf_adr.
  - A read that hits pf_adr while pf_valid is set goes IDLE to ACK, with dat_o=pf_data and ack 1 cycle after the request. The hit also launches the next prefetch.
  - A request arriving during a prefetch waits until the prefetch completes.
  - Any write, and reset, clears pf_valid.
- Without SRAM_PREFETCH_EN: no prefetch states or registers exist, and every read uses the full sequence.

Test Plan:
- WAIT_CYCLES=2; SRAM model preloaded 0x0000:0x1234, 0x0001:0xABCD; read adr 0x0 -> dat_o=0x1234ABCD, ack in cycle 5 after sample, oe_n low for 4 cycles, we_n never low.
- Write adr 0x8, dat 0xDEADBEEF, sel 1111 -> halfword 4 = 0xDEAD, halfword 5 = 0xBEEF, we_n low 2 cycles per half with a 1-cycle gap, ack at cycle 6, single cycle.
- Write adr 0xC, sel 0010, dat 0x0000AA00 -> only halfword 7 written, ub_n=0 and lb_n=1, ack at cycle 3, halfword 6 untouched on readback.
- Assert rst_i during RD_HI -> all strobes high asynchronously, ack_o=0, dat_o=0; next read completes normally.
- Drop cyc_i during WR_LO -> WR_HI still completes, no ack, FSM back in IDLE.
- SRAM_PREFETCH_EN: sequential reads at 0x0, 0x4, 0x8 -> second and third reads ack 1 cycle after request once prefetch is done; a write to 0x4 followed by a read of 0x4 returns the new data via the full sequence.
